dmem_shared_arb: RTL and testbench

Parametrised multi-core data memory: one private bank per core plus one shared single-port bank. It replaces the fixed two-core clock-gated design with a fully synchronous one. Shared accesses go through a round-robin arbiter with a per-core stall handshake. It sits between the NCORES execute stages and the data address space.

---
 rtl/dmem_shared_arb.sv | 98 +++++++++
 tb/tb_dmem_shared_arb.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_shared_arb.sv
// dmem_shared_arb: one private data bank per core plus a shared single-port bank behind a round-robin arbiter.
// Build option DMEM_ATOMIC_SWAP_EN turns a same-cycle load+write into an atomic read-then-write swap.
module dmem_shared_arb #(
  parameter int unsigned NCORES = 2,
  parameter int unsigned LMEM   = 8,
  parameter int unsigned TAM    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCORES*TAM-1:0]  data_in,
  input  logic [NCORES*TAM-1:0]  data_addr,
  input  logic [NCORES-1:0]      data_load,
  input  logic [NCORES-1:0]      data_write,
  output logic [NCORES*TAM-1:0]  data_out,
  output logic [NCORES-1:0]      data_valid,
  output logic [NCORES-1:0]      data_stall
);

  localparam int unsigned WORDS = 1 << LMEM;
  localparam int unsigned PW    = (NCORES > 1) ? $clog2(NCORES) : 1;
`ifdef DMEM_ATOMIC_SWAP_EN
  localparam bit SWAP_EN = 1'b1;
`else
  localparam bit SWAP_EN = 1'b0;
`endif

  logic [TAM-1:0]    wrData  [NCORES];
  logic [LMEM-1:0]   wordIdx [NCORES];
  logic [TAM-1:0]    outReg  [NCORES];
  logic [NCORES-1:0] req;
  logic [NCORES-1:0] shr;
  logic [NCORES-1:0] grant;
  logic [NCORES-1:0] access;
  logic [NCORES-1:0] rdEn;
  logic [PW-1:0]     rrPtr;
  logic [PW-1:0]     grantIdx;
  logic              anyGrant;
  logic              unusedAddrBits;

  logic [TAM-1:0] privMem   [NCORES][WORDS];
  logic [TAM-1:0] sharedMem [WORDS];

  for (genvar i = 0; i < NCORES; i++) begin : g_core
    assign wrData[i]  = data_in[i*TAM +: TAM];
    assign wordIdx[i] = data_addr[i*TAM +: LMEM];
    assign req[i]     = data_load[i] | data_write[i];
    assign shr[i]     = req[i] & data_addr[i*TAM + LMEM];
    assign data_out[i*TAM +: TAM] = outReg[i];
  end

  // Address bits above the bank-select bit are deliberately ignored.
  assign unusedAddrBits = ^data_addr;

  // Round-robin search starting at rrPtr, wrapping modulo NCORES.
  always_comb begin
    int unsigned cand;
    grant    = '0;
    grantIdx = '0;
    anyGrant = 1'b0;
    cand     = 0;
    for (int unsigned k = 0; k < NCORES; k++) begin
      cand = 32'(rrPtr) + k;
      if (cand >= NCORES) cand = cand - NCORES;
      if (!anyGrant && shr[PW'(cand)]) begin
        grant[PW'(cand)] = 1'b1;
        grantIdx         = PW'(cand);
        anyGrant         = 1'b1;
      end
    end
  end

  assign data_stall = shr & ~grant;
  assign access     = req & (~shr | grant);
  assign rdEn       = access & data_load & (~data_write | {NCORES{SWAP_EN}});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rrPtr      <= '0;
      data_valid <= '0;
      for (int unsigned i = 0; i < NCORES; i++) outReg[i] <= '0;
    end else begin
      if (anyGrant) rrPtr <= (grantIdx == PW'(NCORES - 1)) ? '0 : grantIdx + 1'b1;
      data_valid <= rdEn;
      for (int unsigned i = 0; i < NCORES; i++) begin
        if (rdEn[i]) outReg[i] <= shr[i] ? sharedMem[wordIdx[i]] : privMem[i][wordIdx[i]];
      end
    end
  end

  // Reads above sample the pre-edge contents, so a load+write to one word is read-first.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NCORES; i++) begin
      if (access[i] && data_write[i] && !shr[i]) privMem[i][wordIdx[i]] <= wrData[i];
    end
    if (anyGrant && data_write[grantIdx]) sharedMem[wordIdx[grantIdx]] <= wrData[grantIdx];
  end

endmodule

// File: tb/tb_dmem_shared_arb.sv
// Scoreboard bench for dmem_shared_arb (NCORES=4): directed scenarios plus randomized traffic vs a bank model.
module tb_dmem_shared_arb;

  localparam int unsigned NC    = 4;
  localparam int unsigned LM    = 8;
  localparam int unsigned TW    = 16;
  localparam int unsigned WORDS = 1 << LM;
`ifdef DMEM_ATOMIC_SWAP_EN
  localparam bit SWAP = 1'b1;
`else
  localparam bit SWAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NC*TW-1:0] data_in   = '0;
  logic [NC*TW-1:0] data_addr = '0;
  logic [NC-1:0]    data_load  = '0;
  logic [NC-1:0]    data_write = '0;
  logic [NC*TW-1:0] data_out;
  logic [NC-1:0]    data_valid;
  logic [NC-1:0]    data_stall;

  dmem_shared_arb #(.NCORES(NC), .LMEM(LM), .TAM(TW)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_addr(data_addr),
    .data_load(data_load), .data_write(data_write), .data_out(data_out),
    .data_valid(data_valid), .data_stall(data_stall)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  bit          opLoad  [NC];
  bit          opWrite [NC];
  logic [TW-1:0] opAddr [NC];
  logic [TW-1:0] opData [NC];

  logic [TW-1:0] privM [NC][WORDS];
  logic [TW-1:0] shM   [WORDS];
  int unsigned   rr;
  logic [TW-1:0] expQ  [NC][$];
  logic [TW-1:0] expOut [NC];
  logic [NC-1:0] lastStall;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [TW-1:0] mkAddr(input bit sh, input int unsigned idx);
    logic [TW-1:0] a;
    a = TW'($urandom);
    a[LM] = sh;
    a[LM-1:0] = LM'(idx);
    return a;
  endfunction

  task automatic setOp(input int i, input bit ld, input bit wr, input bit sh,
                       input int unsigned idx, input int unsigned dat);
    opLoad[i]  = ld;
    opWrite[i] = wr;
    opAddr[i]  = mkAddr(sh, idx);
    opData[i]  = TW'(dat);
  endtask

  task automatic idle();
    for (int i = 0; i < NC; i++) setOp(i, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  // Cores whose request was accepted last cycle drop it; stalled cores keep theirs.
  task automatic releaseGranted();
    for (int i = 0; i < NC; i++) if (!lastStall[i]) setOp(i, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  // One cycle: drive ops, check stall, apply the bank model and queue expected reads.
  task automatic step();
    logic [NC-1:0] shrV, gntV, expStall;
    int g;
    int unsigned c;
    logic [LM-1:0] idx;
    logic [TW-1:0] old;
    @(negedge clk);
    for (int i = 0; i < NC; i++) begin
      data_load[i]  = opLoad[i];
      data_write[i] = opWrite[i];
      data_addr[i*TW +: TW] = opAddr[i];
      data_in[i*TW +: TW]   = opData[i];
    end
    #1;
    shrV = '0;
    for (int i = 0; i < NC; i++) shrV[i] = (opLoad[i] | opWrite[i]) & opAddr[i][LM];
    g = -1;
    for (int k = 0; k < NC; k++) begin
      c = (rr + k) % NC;
      if (g < 0 && shrV[c]) g = int'(c);
    end
    gntV = '0;
    if (g >= 0) gntV[g] = 1'b1;
    expStall = shrV & ~gntV;
    check("data_stall", data_stall, expStall);
    lastStall = expStall;
    if (rst) begin
      for (int i = 0; i < NC; i++) begin
        if ((opLoad[i] || opWrite[i]) && !expStall[i]) begin
          idx = opAddr[i][LM-1:0];
          old = shrV[i] ? shM[idx] : privM[i][idx];
          if (opLoad[i] && (!opWrite[i] || SWAP)) expQ[i].push_back(old);
          if (opWrite[i]) begin
            if (shrV[i]) shM[idx] = opData[i];
            else privM[i][idx] = opData[i];
          end
        end
      end
      if (g >= 0) rr = (int'(g) + 1) % NC;
    end
  endtask

  task automatic applyReset();
    for (int i = 0; i < NC; i++) begin
      expQ[i].delete();
      expOut[i] = '0;
    end
    rr = 0;
    lastStall = '0;
    idle();
    data_load  = '0;
    data_write = '0;
    rst = 1'b0;
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_valid"}, data_valid, '0);
    check({tag, "_out"}, data_out, '0);
  endtask

  // Monitor: every valid pops the expected word; otherwise data_out must hold.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < NC; i++) begin
      if (data_valid[i] === 1'b1) begin
        if (expQ[i].size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid core%0d: got data_out %0h, required no valid", i, data_out[i*TW +: TW]);
        end else begin
          expOut[i] = expQ[i].pop_front();
          check($sformatf("read_core%0d", i), data_out[i*TW +: TW], expOut[i]);
        end
      end else begin
        check($sformatf("hold_core%0d", i), {data_valid[i], data_out[i*TW +: TW]}, {1'b0, expOut[i]});
      end
    end
  end

  initial begin
    int consec [NC];
    int maxRun;
    int gIdx;
    rr = 0;
    lastStall = '0;
    for (int i = 0; i < NC; i++) expOut[i] = '0;
    idle();

    // Power-on reset; stall is combinational even while in reset.
    #1 rst = 1'b0;
    #1 checkResetOutputs("reset");
    setOp(0, 1'b1, 1'b0, 1'b1, 3, 0);
    setOp(1, 1'b1, 1'b0, 1'b1, 3, 0);
    step();
    idle();
    step();
    releaseReset();

    // Fill every bank so later reads never see uninitialised words.
    for (int w = 0; w < int'(WORDS); w++) begin
      for (int i = 0; i < NC; i++) setOp(i, 1'b0, 1'b1, 1'b0, w, $urandom);
      step();
    end
    idle();
    for (int w = 0; w < int'(WORDS); w++) begin
      setOp(0, 1'b0, 1'b1, 1'b1, w, $urandom);
      step();
    end
    idle();
    step();

    // Private isolation.
    setOp(0, 1'b0, 1'b1, 1'b0, 'h10, 'hAAAA);
    setOp(1, 1'b0, 1'b1, 1'b0, 'h10, 'h5555);
    step();
    setOp(0, 1'b1, 1'b0, 1'b0, 'h10, 0);
    setOp(1, 1'b1, 1'b0, 1'b0, 'h10, 0);
    step();
    idle();
    step();
    step();

    // Shared contention right after reset: core0 wins, core1 stalls one cycle.
    @(negedge clk);
    applyReset();
    #1 checkResetOutputs("reset2");
    releaseReset();
    setOp(0, 1'b0, 1'b1, 1'b1, 'h05, 'h1111);
    setOp(1, 1'b0, 1'b1, 1'b1, 'h05, 'h2222);
    step();
    check("contention_stall1", lastStall, 4'b0010);
    releaseGranted();
    step();
    idle();
    setOp(0, 1'b1, 1'b0, 1'b1, 'h05, 0);
    step();
    idle();
    step();
    step();

    // Read-first on a private word.
    setOp(0, 1'b0, 1'b1, 1'b0, 'h20, 'h1234);
    step();
    setOp(0, 1'b1, 1'b1, 1'b0, 'h20, 'hBEEF);
    step();
    setOp(0, 1'b1, 1'b0, 1'b0, 'h20, 0);
    step();
    idle();
    step();
    step();

    // Fairness: all cores stream shared reads from a fresh rr pointer.
    @(negedge clk);
    applyReset();
    releaseReset();
    for (int i = 0; i < NC; i++) begin
      setOp(i, 1'b1, 1'b0, 1'b1, $urandom_range(0, WORDS - 1), 0);
      consec[i] = 0;
    end
    maxRun = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      step();
      gIdx = -1;
      for (int j = 0; j < NC; j++) begin
        if (opAddr[j][LM] && data_stall[j] === 1'b0) gIdx = j;
        consec[j] = (data_stall[j] === 1'b1) ? consec[j] + 1 : 0;
        if (consec[j] > maxRun) maxRun = consec[j];
      end
      check("rr_order", gIdx, cyc % NC);
      if (gIdx >= 0) setOp(gIdx, 1'b1, 1'b0, 1'b1, $urandom_range(0, WORDS - 1), 0);
    end
    check("max_stall_run_ok", maxRun <= int'(NC) - 1, 1);
    idle();
    step();
    step();

    // Reset while a shared read is in flight: no valid, outputs cleared, rr back to 0.
    setOp(2, 1'b1, 1'b0, 1'b1, 'h33, 0);
    step();
    #2 applyReset();
    @(posedge clk);
    #1 checkResetOutputs("midread");
    releaseReset();
    step();
    check("midread_valid_after", data_valid, '0);
    setOp(0, 1'b1, 1'b0, 1'b1, 'h11, 0);
    setOp(3, 1'b1, 1'b0, 1'b1, 'h22, 0);
    step();
    check("rr_reset_stall", lastStall, 4'b1000);
    releaseGranted();
    step();
    idle();
    step();
    step();

    // Swap on a shared word from two cores.
    setOp(0, 1'b0, 1'b1, 1'b1, 'h00, 'h0000);
    step();
    setOp(0, 1'b1, 1'b1, 1'b1, 'h00, 'h0001);
    setOp(1, 1'b1, 1'b1, 1'b1, 'h00, 'h0001);
    step();
    releaseGranted();
    step();
    idle();
    step();
    step();

    // Randomized traffic; stalled cores hold their request.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NC; i++) begin
        if (!lastStall[i]) begin
          int unsigned r;
          int unsigned idx;
          r = $urandom_range(0, 9);
          idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, WORDS - 1) : $urandom_range(0, 7);
          if (r < 3)      setOp(i, 1'b0, 1'b0, 1'b0, 0, 0);
          else if (r < 6) setOp(i, 1'b1, 1'b0, 1'($urandom_range(0, 1)), idx, 0);
          else if (r < 9) setOp(i, 1'b0, 1'b1, 1'($urandom_range(0, 1)), idx, $urandom);
          else            setOp(i, 1'b1, 1'b1, 1'($urandom_range(0, 1)), idx, $urandom);
        end
      end
      step();
    end
    idle();
    step();
    step();
    step();

    for (int i = 0; i < NC; i++) check($sformatf("pending_reads_core%0d", i), expQ[i].size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
